// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS bus arbiter: FSM states, owner encoding and the
// bus command record held while the slave stalls.
package mips_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_cmd_t;

endpackage

// File: rtl/bus_cmd_reg.sv
// Bus command register: captures a granted command and holds it unchanged
// while the slave stalls; strobes drop once the transfer is accepted.
module bus_cmd_reg
  import mips_bus_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     load,
  input  logic     done,
  input  bus_cmd_t cmd_in,
  output bus_cmd_t cmd
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cmd <= '0;
    end else if (load) begin
      cmd <= cmd_in;
    end else if (done) begin
      // Address/data/lanes keep their last value; only the strobes retire.
      cmd.rd <= 1'b0;
      cmd.wr <= 1'b0;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-style memory port between instruction fetch and MEM-stage
// data access, with bounded data priority and a drain-before-halt rule.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic        d_ack,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  input  logic        halt_req,
  output logic        halted,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        owner,
  output logic        state_dbg
);

  // Requester handshake: a requester holds req (and its addr/wdata) until it
  // sees its one-cycle ack; the command then appears on the bus next cycle
  // and stays stable while waitrequest is high.
  localparam int RW = $clog2(MAX_DATA_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DATA_RUN);

  state_t        state, state_nxt;
  bus_cmd_t      cmd, cmd_nxt;
  logic [RW-1:0] run_cnt;
  logic          halt_latched;
  logic          d_req;
  logic          done;

  assign d_req = d_read | d_write;

  always_comb begin
    state_nxt = state;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    done      = 1'b0;
    cmd_nxt   = '0;
    case (state)
      IDLE: begin
        if (reset) begin
          if (if_req && !halt_latched && (!d_req || run_cnt == RUN_MAX)) begin
            if_ack        = 1'b1;
            cmd_nxt.addr  = if_addr;
            cmd_nxt.rd    = 1'b1;
            cmd_nxt.wr    = 1'b0;
            cmd_nxt.wdata = '0;
            cmd_nxt.be    = 4'b1111;
            state_nxt     = BUSY;
          end else if (d_req) begin
            // A simultaneous read+write is issued as a write only.
            d_ack         = 1'b1;
            cmd_nxt.addr  = d_addr;
            cmd_nxt.rd    = d_read & ~d_write;
            cmd_nxt.wr    = d_write;
            cmd_nxt.wdata = d_wdata;
            cmd_nxt.be    = d_byteenable;
            state_nxt     = BUSY;
          end
        end
      end
      BUSY: begin
        if (!waitrequest) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      run_cnt      <= '0;
      halt_latched <= 1'b0;
      owner        <= OWN_FETCH;
      if_rvalid    <= 1'b0;
      d_rvalid     <= 1'b0;
      if_rdata     <= '0;
      d_rdata      <= '0;
    end else begin
      state <= state_nxt;
      if (halt_req) halt_latched <= 1'b1;

      if (if_ack) begin
        run_cnt <= '0;
        owner   <= OWN_FETCH;
      end else if (d_ack) begin
        owner <= OWN_DATA;
        if (!if_req) run_cnt <= '0;
        else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + RW'(1);
      end

      // Read data returns to whoever issued the command; the other side holds.
      if_rvalid <= done && cmd.rd && (owner == OWN_FETCH);
      d_rvalid  <= done && cmd.rd && (owner == OWN_DATA);
      if (done && cmd.rd) begin
        if (owner == OWN_FETCH) if_rdata <= readdata;
        else                    d_rdata  <= readdata;
      end
    end
  end

  bus_cmd_reg u_cmd_reg (
    .clk    (clk),
    .reset  (reset),
    .load   (if_ack | d_ack),
    .done   (done),
    .cmd_in (cmd_nxt),
    .cmd    (cmd)
  );

  assign address    = cmd.addr;
  assign read       = cmd.rd;
  assign write      = cmd.wr;
  assign writedata  = cmd.wdata;
  assign byteenable = cmd.be;
  assign halted     = halt_latched && (state == IDLE) && !d_req;
  assign state_dbg  = (state == BUSY);

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: a stall-programmable slave, a grant and
// response scoreboard, and cycle-exact checks of the bus command.
module tb_mips_bus_arbiter;

  localparam logic [1:0] G_F = 2'b10;
  localparam logic [1:0] G_D = 2'b01;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteenable;
  logic        d_ack;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        halt_req;
  logic        halted;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        owner;
  logic        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int wait_n   = 0;
  int wcnt     = 0;

  logic [1:0]  grant_q[$];
  logic [33:0] resp_q[$];
  logic [1:0]  eg;
  logic [33:0] er;
  int          exp_run[6];

  mips_bus_arbiter #(.MAX_DATA_RUN(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byteenable(d_byteenable), .d_ack(d_ack), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .halt_req(halt_req), .halted(halted),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
    .owner(owner), .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  // Slave: stalls each command for wait_n cycles, then accepts it.
  always begin
    @(posedge clk);
    #1;
    if ((read || write) && wcnt < wait_n) begin
      waitrequest = 1'b1;
      wcnt++;
    end else begin
      waitrequest = 1'b0;
      wcnt = 0;
    end
  end

  // Monitor: every ack and every rvalid must match the next expected entry.
  always @(negedge clk) begin
    if (if_ack || d_ack) begin
      if (grant_q.size() == 0) begin
        check("unexpected_grant", {62'd0, if_ack, d_ack}, 64'd0);
      end else begin
        eg = grant_q.pop_front();
        check("grant_order", {62'd0, if_ack, d_ack}, {62'd0, eg});
      end
    end
    if (if_rvalid || d_rvalid) begin
      if (resp_q.size() == 0) begin
        check("unexpected_rvalid", {30'd0, if_rvalid, d_rvalid, 32'd0}, 64'd0);
      end else begin
        er = resp_q.pop_front();
        check("response", {30'd0, if_rvalid, d_rvalid, (if_rvalid ? if_rdata : d_rdata)},
              {30'd0, er});
      end
    end
  end

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; d_byteenable = '0; halt_req = 1'b0;
    readdata = '0; waitrequest = 1'b0;
    exp_run = '{1, 2, 3, 4, 0, 1};

    // Reset state
    next_cycle();
    next_cycle();
    at_sample();
    check("reset_strobes", {62'd0, read, write}, 64'd0);
    check("reset_bus", {28'd0, address, byteenable}, 64'd0);
    check("reset_wdata", {32'd0, writedata}, 64'd0);
    check("reset_resp", {if_rdata, d_rdata}, 64'd0);
    check("reset_flags", {58'd0, if_rvalid, d_rvalid, if_ack, d_ack, halted, owner}, 64'd0);
    check("reset_state", {63'd0, state_dbg}, 64'd0);
    next_cycle();
    reset = 1'b1;
    next_cycle();

    // Fetch, zero wait states
    next_cycle();
    if_req = 1'b1; if_addr = 32'hBFC0_0000; readdata = 32'h2402_0005; wait_n = 0;
    grant_q.push_back(G_F);
    resp_q.push_back({2'b10, 32'h2402_0005});
    at_sample();
    check("fetch_ack", {63'd0, if_ack}, 64'd1);
    next_cycle();
    if_req = 1'b0;
    at_sample();
    check("fetch_cmd", {26'd0, read, write, byteenable, address}, {26'd0, 1'b1, 1'b0, 4'hF, 32'hBFC0_0000});
    check("fetch_owner", {63'd0, owner}, 64'd0);
    next_cycle();
    at_sample();
    check("fetch_rvalid", {31'd0, if_rvalid, if_rdata}, {31'd0, 1'b1, 32'h2402_0005});
    check("fetch_read_drop", {63'd0, read}, 64'd0);

    // Store with three wait states; requester inputs change after ack
    next_cycle();
    d_write = 1'b1; d_addr = 32'h0000_1000; d_wdata = 32'hDEAD_BEEF; d_byteenable = 4'b0011;
    wait_n = 3;
    grant_q.push_back(G_D);
    at_sample();
    check("store_ack", {63'd0, d_ack}, 64'd1);
    next_cycle();
    d_write = 1'b0; d_addr = 32'hFFFF_FFFF; d_wdata = 32'h1234_5678; d_byteenable = 4'hF;
    for (int k = 0; k < 4; k++) begin
      at_sample();
      check("store_hold", {write, read, address[29:0], writedata}, {1'b1, 1'b0, 30'h1000, 32'hDEAD_BEEF});
      check("store_be", {60'd0, byteenable}, 64'h3);
      check("store_wait", {63'd0, waitrequest}, (k < 3) ? 64'd1 : 64'd0);
      next_cycle();
    end
    at_sample();
    check("store_write_drop", {63'd0, write}, 64'd0);

    // Fetch and data both pending: D,D,D,D,F,D
    next_cycle();
    if_req = 1'b1; if_addr = 32'h0000_0400; d_read = 1'b1; d_addr = 32'h0000_2000;
    d_byteenable = 4'hF; readdata = 32'h1111_2222; wait_n = 0;
    for (int i = 0; i < 6; i++) begin
      grant_q.push_back((i == 4) ? G_F : G_D);
      resp_q.push_back({((i == 4) ? G_F : G_D), 32'h1111_2222});
    end
    for (int i = 0; i < 6; i++) begin
      at_sample();
      check("arb_grant", {62'd0, if_ack, d_ack}, (i == 4) ? 64'd2 : 64'd1);
      next_cycle();
      if (i == 5) begin
        if_req = 1'b0;
        d_read = 1'b0;
      end
      at_sample();
      check("arb_run_cnt", {61'd0, dut.run_cnt}, 64'(exp_run[i]));
      next_cycle();
    end

    // Read and write together: issued as a write, no response
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h0000_3000; d_wdata = 32'hCAFE_F00D;
    wait_n = 1;
    grant_q.push_back(G_D);
    at_sample();
    check("rw_ack", {63'd0, d_ack}, 64'd1);
    next_cycle();
    d_read = 1'b0; d_write = 1'b0;
    at_sample();
    check("rw_strobes", {62'd0, read, write}, 64'd1);
    check("rw_wdata", {32'd0, writedata}, {32'd0, 32'hCAFE_F00D});
    repeat (4) next_cycle();

    // Halt during a stalled fetch with if_req still high
    if_req = 1'b1; if_addr = 32'h0000_0404; readdata = 32'h8C22_0010; wait_n = 2;
    grant_q.push_back(G_F);
    resp_q.push_back({2'b10, 32'h8C22_0010});
    at_sample();
    check("halt_fetch_ack", {63'd0, if_ack}, 64'd1);
    next_cycle();
    halt_req = 1'b1;
    at_sample();
    check("halt_busy", {63'd0, halted}, 64'd0);
    next_cycle();
    halt_req = 1'b0;
    next_cycle();
    at_sample();
    check("halt_complete", {63'd0, waitrequest}, 64'd0);
    next_cycle();
    next_cycle();
    at_sample();
    check("halted_after", {63'd0, halted}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      at_sample();
      check("halt_no_fetch", {63'd0, if_ack}, 64'd0);
    end
    next_cycle();
    d_read = 1'b1; d_addr = 32'h0000_2004; readdata = 32'h0BAD_F00D; wait_n = 0;
    grant_q.push_back(G_D);
    resp_q.push_back({2'b01, 32'h0BAD_F00D});
    at_sample();
    check("halt_data_ack", {62'd0, d_ack, halted}, 64'd2);
    next_cycle();
    d_read = 1'b0;
    at_sample();
    check("halt_data_busy", {62'd0, read, halted}, 64'd2);
    next_cycle();
    at_sample();
    check("halted_again", {63'd0, halted}, 64'd1);

    // Reset while a read is stalled
    next_cycle();
    if_req = 1'b0;
    d_read = 1'b1; d_addr = 32'h0000_5000; wait_n = 1000;
    grant_q.push_back(G_D);
    next_cycle();
    d_read = 1'b0;
    at_sample();
    check("stall_read", {62'd0, read, waitrequest}, 64'd3);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    at_sample();
    check("rst_busy_strobes", {62'd0, read, write}, 64'd0);
    check("rst_busy_resp", {58'd0, if_rvalid, d_rvalid, if_ack, d_ack, halted, state_dbg}, 64'd0);
    check("rst_busy_addr", {32'd0, address}, 64'd0);
    next_cycle();
    reset = 1'b1; wait_n = 0;

    // Halt latch cleared by reset: fetch is granted again
    next_cycle();
    if_req = 1'b1; if_addr = 32'hBFC0_0004; readdata = 32'h3C1C_1000;
    grant_q.push_back(G_F);
    resp_q.push_back({2'b10, 32'h3C1C_1000});
    at_sample();
    check("post_reset_fetch", {63'd0, if_ack}, 64'd1);
    next_cycle();
    if_req = 1'b0;
    repeat (3) next_cycle();

    at_sample();
    check("grant_q_empty", 64'(grant_q.size()), 64'd0);
    check("resp_q_empty", 64'(resp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
